// File: rtl/req_enc_pkg.sv
// Shared constants and helpers for the request priority encoder.
// idx_w(n) gives the index width max(1, clog2(n)).
package req_enc_pkg;

   localparam int FIXED_PRIO  = 0;
   localparam int ROUND_ROBIN = 1;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational wrap-around picker: first set bit of vec at or above start.
// Ports: vec, start in; found, idx (binary), onehot out.
module prio_pick
   import req_enc_pkg::*;
#(
   parameter int  N = 16,
   localparam int W = idx_w(N)
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot
);

   int pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int i = 0; i < N; i++) begin
         pos = int'(start) + i;
         if (pos >= N) pos = pos - N;
         if (!found && vec[pos]) begin
            found = 1'b1;
            idx   = W'(pos);
         end
      end
      onehot = found ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/req_priority_encoder.sv
// Sticky request accumulator with registered one-per-transfer selection.
// Ports: clk, rst_n, req_i, mask_i, out_ready in; out_valid, out_idx,
// out_onehot, out_multi, pend_o out.
module req_priority_encoder
   import req_enc_pkg::*;
#(
   parameter int  N  = 16,
   parameter int  RR = FIXED_PRIO,
   localparam int W  = idx_w(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] mask_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         out_multi,
   output logic [N-1:0] pend_o
);

   logic [N-1:0] pend;
   logic [N-1:0] cand;
   logic [N-1:0] elig;
   logic [N-1:0] sel_oh;
   logic [N-1:0] clr;
   logic [N-1:0] pend_nxt;
   logic [W-1:0] sel_idx;
   logic [W-1:0] start;
   logic         sel_found;
   logic         load;
   logic         multi;

   assign cand  = pend | req_i;
   assign elig  = cand & ~mask_i;
   assign load  = (!out_valid || out_ready) && sel_found;
   assign multi = |(elig & (elig - N'(1)));

   prio_pick #(.N(N)) u_pick (
      .vec    (elig),
      .start  (start),
      .found  (sel_found),
      .idx    (sel_idx),
      .onehot (sel_oh)
   );

   // A bit that was already pending and re-fires on the
   // selection edge is a fresh event, so it must survive.
   assign clr      = sel_oh & ~(pend & req_i);
   assign pend_nxt = load ? (cand & ~clr) : cand;

   if (RR == ROUND_ROBIN) begin : g_rr
      logic [W-1:0] ptr;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)    ptr <= W'(N - 1);
         else if (load) ptr <= sel_idx;
      end

      assign start = (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
   end else begin : g_fixed
      assign start = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= '0;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         out_multi  <= 1'b0;
      end else begin
         pend <= pend_nxt;
         if (load) begin
            out_valid  <= 1'b1;
            out_idx    <= sel_idx;
            out_onehot <= sel_oh;
            out_multi  <= multi;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_multi <= 1'b0;
         end
      end
   end

   assign pend_o = pend;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Bench for req_priority_encoder: N=16 fixed and N=5 round-robin
// instances, directed scenarios plus random traffic against a model.
module tb_req_priority_encoder;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [15:0] req_a, mask_a, oh_a, pend_a;
   logic        ready_a, valid_a, multi_a;
   logic [3:0]  idx_a;

   logic [4:0]  req_b, mask_b, oh_b, pend_b;
   logic        ready_b, valid_b, multi_b;
   logic [2:0]  idx_b;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   req_priority_encoder #(.N(16), .RR(0)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_a),
      .mask_i     (mask_a),
      .out_valid  (valid_a),
      .out_ready  (ready_a),
      .out_idx    (idx_a),
      .out_onehot (oh_a),
      .out_multi  (multi_a),
      .pend_o     (pend_a)
   );

   req_priority_encoder #(.N(5), .RR(1)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_b),
      .mask_i     (mask_b),
      .out_valid  (valid_b),
      .out_ready  (ready_b),
      .out_idx    (idx_b),
      .out_onehot (oh_b),
      .out_multi  (multi_b),
      .pend_o     (pend_b)
   );

   typedef struct {
      logic [15:0] pend;
      bit          valid;
      int          idx;
      logic [15:0] oh;
      bit          multi;
      int          ptr;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t mreset(input int n);
      mstate_t r;
      r.pend  = '0;
      r.valid = 0;
      r.idx   = 0;
      r.oh    = '0;
      r.multi = 0;
      r.ptr   = n - 1;
      return r;
   endfunction

   // One clock of the documented behaviour, written with plain
   // counting and modulo arithmetic.
   function automatic mstate_t mstep(input mstate_t s, input int n,
                                     input bit rr,
                                     input logic [15:0] req,
                                     input logic [15:0] mask,
                                     input bit ready);
      mstate_t     r;
      logic [15:0] cand, elig;
      int          cnt, sel, st;
      r    = s;
      cand = s.pend | req;
      elig = cand & ~mask;
      cnt  = 0;
      for (int k = 0; k < n; k++) if (elig[k]) cnt++;
      r.pend = cand;
      if ((!s.valid || ready) && cnt > 0) begin
         st  = rr ? (s.ptr + 1) % n : 0;
         sel = -1;
         for (int i = 0; i < n; i++)
            if (sel < 0 && elig[(st + i) % n]) sel = (st + i) % n;
         r.pend[sel] = s.pend[sel] & req[sel];
         r.valid     = 1;
         r.idx       = sel;
         r.oh        = '0;
         r.oh[sel]   = 1'b1;
         r.multi     = (cnt > 1);
         r.ptr       = sel;
      end else if (s.valid && ready) begin
         r.valid = 0;
         r.multi = 0;
      end
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      ma = mstep(ma, 16, 1'b0, req_a, mask_a, ready_a);
      mb = mstep(mb, 5, 1'b1, {11'b0, req_b}, {11'b0, mask_b}, ready_b);
      #1;
   endtask

   task automatic test_reset;
      ready_a = 0;
      req_a   = 16'h0001;
      tick();
      req_a = 16'h00F0;
      tick();
      req_a = 16'h0000;
      nvec++;
      if (pend_a !== 16'h00F0 || valid_a !== 1'b1) begin
         nerr++;
         $display("FAIL reset_pre pend=%h v=%b need pend=00f0 v=1",
                  pend_a, valid_a);
      end
      #3 rst_n = 0;
      #1;
      nvec++;
      if ({valid_a, idx_a, oh_a, multi_a, pend_a} !== '0) begin
         nerr++;
         $display("FAIL reset_async_a v=%b i=%0d oh=%h m=%b p=%h need 0",
                  valid_a, idx_a, oh_a, multi_a, pend_a);
      end
      nvec++;
      if ({valid_b, idx_b, oh_b, multi_b, pend_b} !== '0) begin
         nerr++;
         $display("FAIL reset_async_b v=%b i=%0d oh=%h m=%b p=%h need 0",
                  valid_b, idx_b, oh_b, multi_b, pend_b);
      end
      req_a = 16'hFFFF;
      @(posedge clk);
      #1;
      nvec++;
      if (valid_a !== 1'b0 || pend_a !== 16'h0) begin
         nerr++;
         $display("FAIL reset_hold v=%b p=%h need v=0 p=0000",
                  valid_a, pend_a);
      end
      ma    = mreset(16);
      mb    = mreset(5);
      req_a = 16'h0;
      ready_a = 1;
      #2 rst_n = 1;
      tick();
      nvec++;
      if (valid_a !== 1'b0 || pend_a !== 16'h0) begin
         nerr++;
         $display("FAIL reset_idle v=%b p=%h need v=0 p=0000",
                  valid_a, pend_a);
      end
   endtask

   task automatic test_single;
      req_a = 16'h0020;
      tick();
      req_a = 16'h0;
      nvec++;
      if ({valid_a, idx_a, oh_a, multi_a, pend_a}
          !== {1'b1, 4'd5, 16'h0020, 1'b0, 16'h0}) begin
         nerr++;
         $display("FAIL single v=%b i=%0d oh=%h m=%b p=%h need 1/5/0020/0/0",
                  valid_a, idx_a, oh_a, multi_a, pend_a);
      end
      tick();
      nvec++;
      if (valid_a !== 1'b0) begin
         nerr++;
         $display("FAIL single_drop v=%b need 0", valid_a);
      end
   endtask

   task automatic test_multi;
      req_a = 16'h8001;
      tick();
      req_a = 16'h0;
      nvec++;
      if ({valid_a, idx_a, multi_a, pend_a}
          !== {1'b1, 4'd0, 1'b1, 16'h8000}) begin
         nerr++;
         $display("FAIL multi_1 v=%b i=%0d m=%b p=%h need 1/0/1/8000",
                  valid_a, idx_a, multi_a, pend_a);
      end
      tick();
      nvec++;
      if ({valid_a, idx_a, oh_a, multi_a, pend_a}
          !== {1'b1, 4'd15, 16'h8000, 1'b0, 16'h0}) begin
         nerr++;
         $display("FAIL multi_2 v=%b i=%0d oh=%h m=%b p=%h need 1/15/8000/0/0",
                  valid_a, idx_a, oh_a, multi_a, pend_a);
      end
      tick();
      nvec++;
      if ({valid_a, idx_a, oh_a, multi_a}
          !== {1'b0, 4'd15, 16'h8000, 1'b0}) begin
         nerr++;
         $display("FAIL multi_3 v=%b i=%0d oh=%h m=%b need 0/15/8000/0",
                  valid_a, idx_a, oh_a, multi_a);
      end
   endtask

   task automatic test_backpressure_mask;
      ready_a = 0;
      req_a   = 16'h0004;
      tick();
      req_a = 16'h0008;
      tick();
      req_a = 16'h0;
      nvec++;
      if ({valid_a, idx_a, pend_a} !== {1'b1, 4'd2, 16'h0008}) begin
         nerr++;
         $display("FAIL bp_hold v=%b i=%0d p=%h need 1/2/0008",
                  valid_a, idx_a, pend_a);
      end
      mask_a  = 16'h0008;
      ready_a = 1;
      tick();
      nvec++;
      if ({valid_a, idx_a, pend_a} !== {1'b0, 4'd2, 16'h0008}) begin
         nerr++;
         $display("FAIL mask_drop v=%b i=%0d p=%h need 0/2/0008",
                  valid_a, idx_a, pend_a);
      end
      mask_a = 16'h0;
      tick();
      nvec++;
      if ({valid_a, idx_a, oh_a, pend_a}
          !== {1'b1, 4'd3, 16'h0008, 16'h0}) begin
         nerr++;
         $display("FAIL mask_clear v=%b i=%0d oh=%h p=%h need 1/3/0008/0",
                  valid_a, idx_a, oh_a, pend_a);
      end
      tick();
   endtask

   task automatic test_simul;
      ready_a = 0;
      req_a   = 16'h0001;
      tick();
      req_a = 16'h0080;
      tick();
      ready_a = 1;
      nvec++;
      if ({valid_a, idx_a, pend_a} !== {1'b1, 4'd0, 16'h0080}) begin
         nerr++;
         $display("FAIL simul_pre v=%b i=%0d p=%h need 1/0/0080",
                  valid_a, idx_a, pend_a);
      end
      tick();
      req_a = 16'h0;
      nvec++;
      if ({valid_a, idx_a, pend_a} !== {1'b1, 4'd7, 16'h0080}) begin
         nerr++;
         $display("FAIL simul_keep v=%b i=%0d p=%h need 1/7/0080",
                  valid_a, idx_a, pend_a);
      end
      tick();
      nvec++;
      if ({valid_a, idx_a, pend_a} !== {1'b1, 4'd7, 16'h0}) begin
         nerr++;
         $display("FAIL simul_resel v=%b i=%0d p=%h need 1/7/0000",
                  valid_a, idx_a, pend_a);
      end
      tick();
   endtask

   task automatic test_round_robin;
      int exp_seq[5] = '{0, 1, 4, 0, 1};
      ready_b = 1;
      req_b   = 5'b10011;
      for (int i = 0; i < 5; i++) begin
         tick();
         nvec++;
         if (valid_b !== 1'b1 || int'(idx_b) != exp_seq[i]) begin
            nerr++;
            $display("FAIL rr_seq[%0d] v=%b i=%0d need 1/%0d",
                     i, valid_b, idx_b, exp_seq[i]);
         end
      end
      req_b = 5'b0;
      repeat (5) tick();
      nvec++;
      if (valid_b !== 1'b0 || pend_b !== 5'b0) begin
         nerr++;
         $display("FAIL rr_drain v=%b p=%b need 0/00000", valid_b, pend_b);
      end
   endtask

   task automatic test_random;
      for (int c = 0; c < 400; c++) begin
         req_a   = 16'($urandom & $urandom & $urandom);
         mask_a  = 16'($urandom & $urandom);
         ready_a = ($urandom_range(0, 3) != 0);
         req_b   = 5'($urandom & $urandom);
         mask_b  = 5'($urandom & $urandom & $urandom);
         ready_b = ($urandom_range(0, 3) != 0);
         tick();
         nvec++;
         if ({valid_a, idx_a, oh_a, multi_a, pend_a}
             !== {ma.valid, ma.idx[3:0], ma.oh, ma.multi, ma.pend}) begin
            nerr++;
            $display("FAIL rand_a c=%0d got %b/%0d/%h/%b/%h need %b/%0d/%h/%b/%h",
                     c, valid_a, idx_a, oh_a, multi_a, pend_a,
                     ma.valid, ma.idx, ma.oh, ma.multi, ma.pend);
         end
         nvec++;
         if ({valid_b, idx_b, oh_b, multi_b, pend_b}
             !== {mb.valid, mb.idx[2:0], mb.oh[4:0], mb.multi, mb.pend[4:0]}
             || idx_b > 3'd4) begin
            nerr++;
            $display("FAIL rand_b c=%0d got %b/%0d/%b/%b/%b need %b/%0d/%b/%b/%b",
                     c, valid_b, idx_b, oh_b, multi_b, pend_b,
                     mb.valid, mb.idx, mb.oh[4:0], mb.multi, mb.pend[4:0]);
         end
      end
      req_a  = '0;
      mask_a = '0;
      req_b  = '0;
      mask_b = '0;
   endtask

   initial begin
      rst_n   = 0;
      req_a   = '0;
      mask_a  = '0;
      ready_a = 1;
      req_b   = '0;
      mask_b  = '0;
      ready_b = 1;
      ma      = mreset(16);
      mb      = mreset(5);
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      test_reset();
      test_single();
      test_multi();
      test_backpressure_mask();
      test_simul();
      test_round_robin();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
